// File: rtl/seq_scan_ctrl_if.sv
// Word-stream handshake between a producer and the scan controller.
// The producer drives valid/data/last; the controller answers with ready.
interface seq_scan_ctrl_if #(
  parameter int WORD_W = 8
);
  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;

  modport master (output in_valid, in_data, in_last, input in_ready);
  modport slave  (input in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/seq_scan_ctrl.sv
// Streams words MSB first through a programmable 4-bit overlapping detector,
// counting matches per job and raising a sticky threshold interrupt.
module seq_scan_ctrl #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             clear,
  input  logic [3:0]       pattern,
  input  logic [CNT_W-1:0] threshold,
  seq_scan_ctrl_if.slave   in_if,
  output logic             busy,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_count,
  output logic             done,
  output logic             irq
);

  localparam int               BW       = $clog2(WORD_W);
  localparam logic [BW-1:0]    LAST_BIT = BW'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  shreg_q;
  logic               last_q;
  logic [BW-1:0]      bit_idx_q;
  logic [3:0]         hist_q;
  logic [3:0]         pat_q;
  logic [1:0]         seen_q;
  logic [CNT_W-1:0]   thr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               irq_q;
  logic               pulse_q;
  logic               busy_q;
  logic               done_q;

  logic               start_acc;
  logic               word_end;
  logic [3:0]         hist_d;
  logic               match;
  logic [CNT_W-1:0]   cnt_inc;

  assign start_acc = (state_q == S_IDLE) && start;
  assign word_end  = (bit_idx_q == LAST_BIT);
  assign hist_d    = {hist_q[2:0], shreg_q[WORD_W-1]};
  // seen_q saturates at 3: the current bit is then at least the fourth of the job
  assign match     = (state_q == S_SHIFT) && (seen_q == 2'd3) && (hist_d == pat_q);
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  if (in_if.in_valid) state_d = S_SHIFT;
      S_SHIFT: if (word_end) state_d = last_q ? S_DONE : S_LOAD;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_if.in_ready = (state_q == S_LOAD);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shreg_q   <= '0;
      last_q    <= 1'b0;
      bit_idx_q <= '0;
      hist_q    <= '0;
      pat_q     <= '0;
      seen_q    <= '0;
      thr_q     <= '0;
      cnt_q     <= '0;
      irq_q     <= 1'b0;
      pulse_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      pulse_q <= match;

      if (start_acc) begin
        pat_q  <= pattern;
        thr_q  <= threshold;
        hist_q <= '0;
        seen_q <= '0;
      end

      if (state_q == S_LOAD && in_if.in_valid) begin
        shreg_q   <= in_if.in_data;
        last_q    <= in_if.in_last;
        bit_idx_q <= '0;
      end

      if (state_q == S_SHIFT) begin
        shreg_q   <= shreg_q << 1;
        hist_q    <= hist_d;
        bit_idx_q <= bit_idx_q + BW'(1);
        if (seen_q != 2'd3) seen_q <= seen_q + 2'd1;
      end

      // clear (or a fresh job) takes priority over a same-cycle increment
      if (start_acc || clear) begin
        cnt_q <= '0;
        irq_q <= 1'b0;
      end else if (match) begin
        cnt_q <= cnt_inc;
        if (thr_q != '0 && cnt_inc == thr_q) irq_q <= 1'b1;
      end
    end
  end

  assign busy        = busy_q;
  assign match_pulse = pulse_q;
  assign match_count = cnt_q;
  assign done        = done_q;
  assign irq         = irq_q;

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Controller that streams parallel data words, one bit per cycle, MSB first, through a 4-bit programmable overlapping pattern detector. It counts matches per job and raises a sticky interrupt when a programmed threshold is reached. It sits between a word-wide producer (valid/ready) and the status/interrupt logic, and generalises the fixed "1010" Mealy detector into a scheduled, software-configured resource.

## Interface
- WORD_W, 8, data word width in bits (≥4)
- CNT_W, 8, width of match counter and threshold
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins a job when idle, ignored when busy
- clear  in  1  zeroes match_count and irq (any state)
- pattern  in  4  target bit pattern, oldest bit at [3]; sampled on accepted start
- threshold  in  CNT_W  irq level; sampled on accepted start; 0 disables irq
- in_valid  in  1  producer word valid
- in_data  in  WORD_W  producer word
- in_last  in  1  marks final word of job, qualified by in_valid
- in_ready  out  1  controller can accept a word
- busy  out  1  high from cycle after accepted start until DONE exits
- match_pulse  out  1  one-cycle pulse per detected match
- match_count  out  CNT_W  matches in current/last job, saturating
- done  out  1  one-cycle pulse at job end
- irq  out  1  sticky threshold interrupt

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: in_ready=0, busy=0. start → LOAD; latch pattern/threshold; clear history, bit-valid counter, match_count, irq.
- LOAD: in_ready=1. On in_valid&&in_ready capture in_data into shift register and in_last into last flag → SHIFT. Otherwise stay.
- SHIFT: in_ready=0. Each cycle consume shift-register MSB, shift left, history ← {history[2:0], bit}. After WORD_W bits: last flag → DONE, else → LOAD.
- DONE: done=1 for one cycle → IDLE. match_count and irq retain values after job end.
- Detection: match when new history equals latched pattern and at least 4 bits consumed since start. Overlap allowed. History carries across word boundaries within a job; history is not reset between words.
- match_count increments by 1 per match and saturates at 2^CNT_W−1.
- irq sets when threshold≠0 and post-increment count equals threshold. It stays set until clear or an accepted start.
- clear and an increment in the same cycle: clear wins, so count=0 and irq=0.
- start while busy: no effect. start and clear in the same cycle in IDLE: start behaviour applies (count and irq cleared anyway).
- reset_n=0 in any state, including mid-SHIFT: next edge forces IDLE and all registers to reset values. The partial job is discarded with no done.

## Timing
- Reset values: in_ready=0, busy=0, match_pulse=0, match_count=0, done=0, irq=0, state=IDLE.
- start sampled in cycle T: LOAD and busy=1 in T+1, in_ready=1 in T+1.
- Word accepted in cycle A: SHIFT for cycles A+1..A+WORD_W. Bit k (0=MSB) is consumed in A+1+k.
- Match on bit consumed in cycle C: match_pulse=1 and match_count updated in C+1; irq visible in C+1.
- Next LOAD (in_ready=1) at A+WORD_W+1. Sustained throughput is one word per WORD_W+1 cycles.
- Last word: DONE (done=1, busy=1) at A+WORD_W+1, IDLE at A+WORD_W+2. match_pulse for the final bit coincides with done.
- All outputs are registered except in_ready, which decodes state.

## Test plan
- Basic job: reset, pattern=4'b1010, threshold=0, start at T; word 0xAA with in_last offered at T+1. Required: in_ready=1 at T+1; match_pulse at T+6, T+8, T+10; done at T+10; match_count=3; irq=0; busy low at T+11.
- Cross-word overlap: pattern=1010; words 0x0A then 0xA0 (last). Required: match at end of word 1, two in word 2; match_count=3; no match before 4 bits consumed.
- Threshold and clear: pattern=1010, threshold=2, word 0xAA. Required: irq rises with second match_pulse and stays high after done. clear pulse gives count=0 and irq=0 next cycle. clear coincident with a match_pulse cycle gives count=0.
- Saturation: CNT_W=2, pattern=0000, word 0x00 (5 matches). Required: match_count stops at 3 while match_pulse still fires 5 times.
- Back-pressure and start-while-busy: in_valid held low 5 cycles in LOAD, then 0xAA. Required: state holds with in_ready=1. A start pulse during SHIFT changes nothing; result is identical to the basic job shifted by 5 cycles.
- Reset mid-SHIFT: reset_n=0 for one cycle at bit 3 of a word. Required: next cycle all outputs at reset values, no done, and a new start runs a clean job.
